// File: rtl/clock_tick_monitor.sv
// Slow-clock receiver: synchronises a divided clock into in_clk, emits rise/fall ticks,
// measures the rise-to-rise period and reports lock and stall status.
//
// state   | meaning
// IDLE    | no reference rising edge yet (after reset or after a stall)
// ACQUIRE | counting consecutive consistent periods toward lock
// LOCKED  | period stable within TOL for LOCK_COUNT measurements
module clock_tick_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 32,
  parameter int TIMEOUT     = 200000,
  parameter int LOCK_COUNT  = 4,
  parameter int TOL         = 2
) (
  input  logic             in_clk,
  input  logic             rst,
  input  logic             slow_clk,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             stalled
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sync;
  logic                   hist;
  logic                   sync_out;
  logic                   rise_ev;
  logic                   fall_ev;

  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       match, match_nxt, match_inc;
  logic [CNT_W-1:0] last_period, last_nxt;
  logic [CNT_W-1:0] period_nxt;
  logic             pv_nxt;
  logic             stalled_nxt;
  logic             locked_nxt;

  logic [CNT_W:0]   cnt_ext;
  logic [CNT_W:0]   last_ext;
  logic [CNT_W:0]   dev;
  logic             dev_over;
  logic             timeout_hit;
  logic [CNT_W-1:0] cnt_inc;

  // Synchroniser plus one history flop; edges are judged on the last sync stage.
  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      hist <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], slow_clk};
      hist <= sync[SYNC_STAGES-1];
    end
  end

  assign sync_out = sync[SYNC_STAGES-1];
  assign rise_ev  = sync_out & ~hist;
  assign fall_ev  = ~sync_out & hist;

  // Deviation is taken one bit wider so the subtraction can never wrap.
  assign cnt_ext     = {1'b0, cnt};
  assign last_ext    = {1'b0, last_period};
  assign dev         = (cnt >= last_period) ? (cnt_ext - last_ext) : (last_ext - cnt_ext);
  assign dev_over    = dev > (CNT_W+1)'(TOL);
  assign timeout_hit = cnt >= CNT_W'(TIMEOUT);
  assign cnt_inc     = (&cnt) ? cnt : cnt + 1'b1;
  assign match_inc   = ((match == 4'd0) || dev_over) ? 4'd1 : match + 4'd1;

  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    match_nxt   = match;
    last_nxt    = last_period;
    period_nxt  = period;
    pv_nxt      = 1'b0;
    stalled_nxt = stalled;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (rise_ev) begin
          state_nxt   = ACQUIRE;
          cnt_nxt     = {{(CNT_W-1){1'b0}}, 1'b1};
          match_nxt   = 4'd0;
          stalled_nxt = 1'b0;
        end
      end
      ACQUIRE: begin
        if (rise_ev) begin
          cnt_nxt    = {{(CNT_W-1){1'b0}}, 1'b1};
          period_nxt = cnt;
          pv_nxt     = 1'b1;
          last_nxt   = cnt;
          match_nxt  = match_inc;
          if (match_inc == 4'(LOCK_COUNT)) begin
            state_nxt = LOCKED;
          end
        end else if (timeout_hit) begin
          state_nxt   = IDLE;
          stalled_nxt = 1'b1;
          cnt_nxt     = '0;
          match_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      LOCKED: begin
        if (rise_ev) begin
          cnt_nxt    = {{(CNT_W-1){1'b0}}, 1'b1};
          period_nxt = cnt;
          pv_nxt     = 1'b1;
          last_nxt   = cnt;
          if (dev_over) begin
            state_nxt = ACQUIRE;
            match_nxt = 4'd1;
          end
        end else if (timeout_hit) begin
          state_nxt   = IDLE;
          stalled_nxt = 1'b1;
          cnt_nxt     = '0;
          match_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        match_nxt = 4'd0;
      end
    endcase
    locked_nxt = (state_nxt == LOCKED);
  end

  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      match        <= 4'd0;
      last_period  <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      stalled      <= 1'b0;
      rise_tick    <= 1'b0;
      fall_tick    <= 1'b0;
    end else begin
      cnt          <= cnt_nxt;
      match        <= match_nxt;
      last_period  <= last_nxt;
      period       <= period_nxt;
      period_valid <= pv_nxt;
      locked       <= locked_nxt;
      stalled      <= stalled_nxt;
      rise_tick    <= rise_ev;
      fall_tick    <= fall_ev;
    end
  end

endmodule

// File: tb/tb_clock_tick_monitor.sv
// Directed bench for clock_tick_monitor with TIMEOUT shortened to 1000 cycles.
// Inputs change on the falling edge of in_clk; outputs are sampled there too.
module tb_clock_tick_monitor;

  localparam int CNT_W = 32;

  logic             in_clk = 1'b0;
  logic             rst = 1'b1;
  logic             slow_clk = 1'b0;
  logic             rise_tick;
  logic             fall_tick;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             locked;
  logic             stalled;

  int tests_run = 0;
  int tests_failed = 0;

  int cyc = 0;
  int n_rise, n_fall, n_pv, n_dbl;
  int first_rise_cyc, first_fall_cyc, first_pv_cyc;
  int n_lock_on, n_lock_off, lock_on_cyc, lock_off_cyc;
  int n_stall_on, n_stall_off, stall_on_cyc, stall_off_cyc;
  logic prev_rise = 1'b0, prev_fall = 1'b0, prev_locked = 1'b0, prev_stalled = 1'b0;
  logic [CNT_W-1:0] pv_q[$];

  clock_tick_monitor #(
    .SYNC_STAGES(2),
    .CNT_W(CNT_W),
    .TIMEOUT(1000),
    .LOCK_COUNT(4),
    .TOL(2)
  ) dut (
    .in_clk(in_clk),
    .rst(rst),
    .slow_clk(slow_clk),
    .rise_tick(rise_tick),
    .fall_tick(fall_tick),
    .period(period),
    .period_valid(period_valid),
    .locked(locked),
    .stalled(stalled)
  );

  always #5 in_clk = ~in_clk;

  task automatic clear_mon();
    n_rise = 0; n_fall = 0; n_pv = 0; n_dbl = 0;
    first_rise_cyc = -1; first_fall_cyc = -1; first_pv_cyc = -1;
    n_lock_on = 0; n_lock_off = 0; lock_on_cyc = -1; lock_off_cyc = -1;
    n_stall_on = 0; n_stall_off = 0; stall_on_cyc = -1; stall_off_cyc = -1;
    pv_q.delete();
  endtask

  // Advance one cycle and record what the outputs did.
  task automatic step();
    @(negedge in_clk);
    cyc++;
    if (rise_tick) begin
      n_rise++;
      if (first_rise_cyc < 0) first_rise_cyc = cyc;
      if (prev_rise) n_dbl++;
    end
    if (fall_tick) begin
      n_fall++;
      if (first_fall_cyc < 0) first_fall_cyc = cyc;
      if (prev_fall) n_dbl++;
    end
    if (period_valid) begin
      n_pv++;
      pv_q.push_back(period);
      if (first_pv_cyc < 0) first_pv_cyc = cyc;
    end
    if (locked && !prev_locked) begin n_lock_on++; lock_on_cyc = cyc; end
    if (!locked && prev_locked) begin n_lock_off++; lock_off_cyc = cyc; end
    if (stalled && !prev_stalled) begin n_stall_on++; stall_on_cyc = cyc; end
    if (!stalled && prev_stalled) begin n_stall_off++; stall_off_cyc = cyc; end
    prev_rise = rise_tick;
    prev_fall = fall_tick;
    prev_locked = locked;
    prev_stalled = stalled;
  endtask

  task automatic half(input logic level, input int n);
    slow_clk = level;
    repeat (n) step();
  endtask

  // One slow period starting with a rising edge.
  task automatic per(input int hi, input int lo);
    half(1'b1, hi);
    half(1'b0, lo);
  endtask

  task automatic test_reset();
    clear_mon();
    repeat (3) step();
    tests_run++;
    if ({rise_tick, fall_tick, period_valid, locked, stalled} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b expected 00000", {rise_tick, fall_tick, period_valid, locked, stalled});
    end
    tests_run++;
    if (period !== '0) begin
      tests_failed++;
      $display("FAIL reset_period: got %0d expected 0", period);
    end
    rst = 1'b0;
    repeat (5) step();
    tests_run++;
    if (n_rise + n_fall + n_pv + n_lock_on + n_stall_on !== 0) begin
      tests_failed++;
      $display("FAIL reset_quiet: got %0d events expected 0", n_rise + n_fall + n_pv + n_lock_on + n_stall_on);
    end
  endtask

  task automatic test_steady();
    int c0;
    clear_mon();
    c0 = cyc;
    repeat (6) per(50, 50);
    tests_run++;
    if (first_rise_cyc !== c0 + 3) begin
      tests_failed++;
      $display("FAIL steady_rise_latency: got %0d expected %0d", first_rise_cyc - c0, 3);
    end
    tests_run++;
    if (first_fall_cyc - first_rise_cyc !== 50) begin
      tests_failed++;
      $display("FAIL steady_fall_offset: got %0d expected 50", first_fall_cyc - first_rise_cyc);
    end
    tests_run++;
    if (n_rise !== 6 || n_fall !== 6 || n_dbl !== 0) begin
      tests_failed++;
      $display("FAIL steady_tick_counts: got rise=%0d fall=%0d dbl=%0d expected 6 6 0", n_rise, n_fall, n_dbl);
    end
    tests_run++;
    if (first_pv_cyc !== c0 + 103) begin
      tests_failed++;
      $display("FAIL steady_first_pv: got %0d expected %0d", first_pv_cyc - c0, 103);
    end
    tests_run++;
    if (n_pv !== 5) begin
      tests_failed++;
      $display("FAIL steady_pv_count: got %0d expected 5", n_pv);
    end
    for (int i = 0; i < pv_q.size(); i++) begin
      tests_run++;
      if (pv_q[i] !== 32'd100) begin
        tests_failed++;
        $display("FAIL steady_period[%0d]: got %0d expected 100", i, pv_q[i]);
      end
    end
    tests_run++;
    if (lock_on_cyc !== c0 + 403 || n_lock_on !== 1) begin
      tests_failed++;
      $display("FAIL steady_lock_time: got %0d (n=%0d) expected %0d", lock_on_cyc - c0, n_lock_on, 403);
    end
  endtask

  task automatic test_jitter_in_tol();
    logic [CNT_W-1:0] exp_p [4];
    exp_p[0] = 32'd100; exp_p[1] = 32'd101; exp_p[2] = 32'd99; exp_p[3] = 32'd101;
    clear_mon();
    per(50, 51);
    per(50, 49);
    per(50, 51);
    per(50, 50);
    tests_run++;
    if (pv_q.size() !== 4) begin
      tests_failed++;
      $display("FAIL jitter_pv_count: got %0d expected 4", pv_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (pv_q[i] !== exp_p[i]) begin
          tests_failed++;
          $display("FAIL jitter_period[%0d]: got %0d expected %0d", i, pv_q[i], exp_p[i]);
        end
      end
    end
    tests_run++;
    if (locked !== 1'b1 || n_lock_off !== 0) begin
      tests_failed++;
      $display("FAIL jitter_lock_held: got locked=%b drops=%0d expected 1 0", locked, n_lock_off);
    end
  endtask

  task automatic test_jitter_out_tol();
    int a1, a4;
    clear_mon();
    per(50, 60);
    a1 = cyc;
    per(50, 60);
    tests_run++;
    if (lock_off_cyc !== a1 + 3 || n_lock_off !== 1) begin
      tests_failed++;
      $display("FAIL outtol_unlock_time: got %0d (n=%0d) expected 3", lock_off_cyc - a1, n_lock_off);
    end
    per(50, 60);
    per(50, 60);
    tests_run++;
    if (locked !== 1'b0) begin
      tests_failed++;
      $display("FAIL outtol_still_acquire: got %b expected 0", locked);
    end
    a4 = cyc;
    per(50, 60);
    tests_run++;
    if (lock_on_cyc !== a4 + 3 || n_lock_on !== 1) begin
      tests_failed++;
      $display("FAIL outtol_relock_time: got %0d (n=%0d) expected 3", lock_on_cyc - a4, n_lock_on);
    end
    tests_run++;
    if (pv_q.size() !== 5 || pv_q[0] !== 32'd100 || pv_q[4] !== 32'd110) begin
      tests_failed++;
      $display("FAIL outtol_periods: got n=%0d expected 5 values 100..110", pv_q.size());
    end
  endtask

  task automatic test_stall();
    int r, r2;
    clear_mon();
    r = cyc;
    half(1'b1, 1100);
    tests_run++;
    if (stall_on_cyc !== r + 1003 || n_stall_on !== 1) begin
      tests_failed++;
      $display("FAIL stall_time: got %0d (n=%0d) expected 1003", stall_on_cyc - r, n_stall_on);
    end
    tests_run++;
    if (lock_off_cyc !== r + 1003 || locked !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_unlock: got %0d locked=%b expected 1003 0", lock_off_cyc - r, locked);
    end
    tests_run++;
    if (period !== 32'd110 || n_pv !== 1) begin
      tests_failed++;
      $display("FAIL stall_period_hold: got %0d (pv=%0d) expected 110 (pv=1)", period, n_pv);
    end
    half(1'b0, 50);
    r2 = cyc;
    per(50, 50);
    tests_run++;
    if (stall_off_cyc !== r2 + 3 || stalled !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_clear: got %0d stalled=%b expected 3 0", stall_off_cyc - r2, stalled);
    end
    tests_run++;
    if (n_pv !== 1) begin
      tests_failed++;
      $display("FAIL stall_no_pv: got %0d expected 1", n_pv);
    end
  endtask

  task automatic test_reset_mid();
    int c;
    repeat (4) per(50, 50);
    half(1'b1, 20);
    tests_run++;
    if (locked !== 1'b1) begin
      tests_failed++;
      $display("FAIL rstmid_prelock: got %b expected 1", locked);
    end
    #3 rst = 1'b1;
    #1;
    tests_run++;
    if ({rise_tick, fall_tick, period_valid, locked, stalled} !== 5'b0 || period !== '0) begin
      tests_failed++;
      $display("FAIL rstmid_async: got flags=%b period=%0d expected 0 0",
               {rise_tick, fall_tick, period_valid, locked, stalled}, period);
    end
    slow_clk = 1'b0;
    repeat (4) step();
    rst = 1'b0;
    repeat (4) step();
    clear_mon();
    c = cyc;
    repeat (6) per(50, 50);
    tests_run++;
    if (first_pv_cyc !== c + 103) begin
      tests_failed++;
      $display("FAIL rstmid_first_pv: got %0d expected 103", first_pv_cyc - c);
    end
    tests_run++;
    if (lock_on_cyc !== c + 403 || n_lock_on !== 1) begin
      tests_failed++;
      $display("FAIL rstmid_relock: got %0d (n=%0d) expected 403", lock_on_cyc - c, n_lock_on);
    end
  endtask

  task automatic test_boundary();
    int b2;
    clear_mon();
    per(500, 500);
    b2 = cyc;
    half(1'b1, 10);
    tests_run++;
    if (n_stall_on !== 0 || stalled !== 1'b0) begin
      tests_failed++;
      $display("FAIL boundary_no_stall: got n=%0d stalled=%b expected 0 0", n_stall_on, stalled);
    end
    tests_run++;
    if (pv_q.size() !== 2 || period !== 32'd1000) begin
      tests_failed++;
      $display("FAIL boundary_period: got %0d (pv=%0d) expected 1000 (pv=2)", period, pv_q.size());
    end
    tests_run++;
    if (lock_off_cyc !== b2 + 3) begin
      tests_failed++;
      $display("FAIL boundary_unlock: got %0d expected 3", lock_off_cyc - b2);
    end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_jitter_in_tol();
    test_jitter_out_tol();
    test_stall();
    test_reset_mid();
    test_boundary();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
